// File: rtl/delta_spike_encoder_if.sv
// Sample-in / event-out stream bundle for the delta spike encoder.
// The master drives samples and consumes events; the encoder is the slave.
interface delta_spike_encoder_if #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8
);
  localparam int CH_W = $clog2(CHANNELS);

  // Sample stream toward the encoder
  logic              sample_valid;
  logic              sample_ready;
  logic [CH_W-1:0]   sample_chan;
  logic [DATA_W-1:0] sample_data;
  logic              load_ref;

  // Event stream toward the spike router
  logic              evt_valid;
  logic              evt_ready;
  logic [CH_W-1:0]   evt_chan;
  logic              evt_pol;

  modport master (
    output sample_valid, sample_chan, sample_data, load_ref, evt_ready,
    input  sample_ready, evt_valid, evt_chan, evt_pol
  );

  modport slave (
    input  sample_valid, sample_chan, sample_data, load_ref, evt_ready,
    output sample_ready, evt_valid, evt_chan, evt_pol
  );
endinterface

// File: rtl/delta_spike_encoder.sv
// Multi-channel delta-modulation spike encoder: per-channel reference and
// refractory counter, ON/OFF event generation, and an event FIFO drained
// over a valid/ready stream.
module delta_spike_encoder #(
  parameter  int CHANNELS   = 4,
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 8,
  parameter  int REF_W      = 4,
  localparam int CH_W       = $clog2(CHANNELS),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  delta_spike_encoder_if.slave  bus,
  input  logic [DATA_W-1:0]     threshold,
  input  logic [REF_W-1:0]      refractory,
  input  logic                  off_en,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic            pol;
  } evt_t;

  logic [DATA_W-1:0] ref_q    [CHANNELS];
  logic [DATA_W-1:0] ref_d    [CHANNELS];
  logic [REF_W-1:0]  rc_q     [CHANNELS];
  logic [REF_W-1:0]  rc_d     [CHANNELS];
  evt_t              mem_q    [FIFO_DEPTH];
  evt_t              mem_d    [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              overflow_q, overflow_d;

  logic                chan_ok;
  logic                accept;
  logic [DATA_W-1:0]   cur_ref;
  logic [REF_W-1:0]    cur_rc;
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] neg_diff;
  logic signed [DATA_W:0] thr_s;
  logic                evt_gen;
  logic                evt_pol_new;
  logic                full;
  logic                push;
  logic                pop;

  assign bus.sample_ready = ~reset;
  assign bus.evt_valid    = (count_q != '0);
  assign bus.evt_chan     = mem_q[rd_ptr_q].chan;
  assign bus.evt_pol      = mem_q[rd_ptr_q].pol;
  assign fifo_count       = count_q;
  assign overflow         = overflow_q;

  // Decode the incoming sample: channel range, current state, signed difference
  always_comb begin
    chan_ok  = ({1'b0, bus.sample_chan} < (CH_W+1)'(CHANNELS));
    accept   = bus.sample_valid & ~reset & chan_ok;
    cur_ref  = ref_q[bus.sample_chan];
    cur_rc   = rc_q[bus.sample_chan];
    diff     = $signed({1'b0, bus.sample_data}) - $signed({1'b0, cur_ref});
    neg_diff = $signed({1'b0, cur_ref}) - $signed({1'b0, bus.sample_data});
    thr_s    = $signed({1'b0, threshold});
  end

  // Per-channel reference/refractory update and event decision
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    ref_d       = ref_q;
    evt_gen     = 1'b0;
    evt_pol_new = 1'b0;
    for (int x = 0; x < CHANNELS; x++) begin
      rc_d[x] = (rc_q[x] != '0) ? rc_q[x] - REF_W'(1) : rc_q[x];
    end
    if (accept) begin
      if (bus.load_ref) begin
        ref_d[bus.sample_chan] = bus.sample_data;
      end else if (cur_rc == '0) begin
        if (diff > thr_s) begin
          ref_d[bus.sample_chan] = bus.sample_data;
          rc_d[bus.sample_chan]  = refractory;
          evt_gen                = 1'b1;
          evt_pol_new            = 1'b1;
        end else if (neg_diff > thr_s) begin
          // The reference follows a falling step even when OFF events are muted
          ref_d[bus.sample_chan] = bus.sample_data;
          rc_d[bus.sample_chan]  = refractory;
          evt_gen                = off_en;
        end
      end
    end
  end

  // Event FIFO: push/pop bookkeeping, drop-on-full with sticky overflow
  always_comb begin
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = bus.evt_valid & bus.evt_ready;
    push       = evt_gen & (~full | pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{chan: bus.sample_chan, pol: evt_pol_new};
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (evt_gen & ~push) begin
      overflow_d = 1'b1;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control and channel state registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      ref_q      <= '{default: '0};
      rc_q       <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ref_q      <= ref_d;
      rc_q       <= rc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; pointers and count alone decide which entries are live.
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_delta_spike_encoder.sv
// Self-checking bench for delta_spike_encoder: directed scenarios plus a
// randomized phase, checked by a scoreboard fed from a behavioural model.
module tb_delta_spike_encoder;
  localparam int CHANNELS   = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int REF_W      = 4;
  localparam int CH_W       = $clog2(CHANNELS);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] threshold = '0;
  logic [REF_W-1:0]  refractory = '0;
  logic              off_en = 1'b0;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;

  delta_spike_encoder_if #(.CHANNELS(CHANNELS), .DATA_W(DATA_W)) bus ();

  delta_spike_encoder #(
    .CHANNELS(CHANNELS), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .REF_W(REF_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .threshold  (threshold),
    .refractory (refractory),
    .off_en     (off_en),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  typedef struct {
    int chan;
    int pol;
  } ev_t;

  ev_t    exp_q[$];
  int     ref_m [CHANNELS];
  longint dead_until [CHANNELS];
  longint cyc = 0;
  bit     ovf_m = 1'b0;
  bit     popped = 1'b0;
  bit     started = 1'b0;

  // Model: at each edge, apply the encoder rules to the sample presented
  initial forever begin
    int  c, d, occ, pol;
    bit  gen;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      ovf_m   = 1'b0;
      started = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        ref_m[i]      = 0;
        dead_until[i] = 0;
      end
    end else if (bus.sample_valid && int'(bus.sample_chan) < CHANNELS) begin
      c   = int'(bus.sample_chan);
      gen = 1'b0;
      pol = 0;
      if (bus.load_ref) begin
        ref_m[c] = int'(bus.sample_data);
      end else if (cyc >= dead_until[c]) begin
        d = int'(bus.sample_data) - ref_m[c];
        if (d > int'(threshold)) begin
          gen = 1'b1;
          pol = 1;
        end else if (-d > int'(threshold)) begin
          gen = off_en;
          pol = 0;
        end
        if (d > int'(threshold) || -d > int'(threshold)) begin
          ref_m[c]      = int'(bus.sample_data);
          dead_until[c] = cyc + longint'(refractory) + 1;
        end
      end
      if (gen) begin
        occ = exp_q.size() + (popped ? 1 : 0);
        if (occ < FIFO_DEPTH || popped) exp_q.push_back('{chan: c, pol: pol});
        else ovf_m = 1'b1;
      end
    end
    popped = 1'b0;
    cyc++;
  end

  // Monitor: mid-cycle, compare outputs with the model and retire popped events
  initial forever begin
    @(negedge clk);
    if (started) begin
      check("sample_ready", 32'(bus.sample_ready), 32'(!reset));
      check("evt_valid", 32'(bus.evt_valid), 32'(exp_q.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      check("overflow", 32'(overflow), 32'(ovf_m));
      if (exp_q.size() != 0 && bus.evt_ready) begin
        check("evt_chan", 32'(bus.evt_chan), 32'(exp_q[0].chan));
        check("evt_pol", 32'(bus.evt_pol), 32'(exp_q[0].pol));
        void'(exp_q.pop_front());
        popped = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int data, input bit load = 1'b0);
    bus.sample_valid = 1'b1;
    bus.sample_chan  = CH_W'(ch);
    bus.sample_data  = DATA_W'(data);
    bus.load_ref     = load;
    tick();
    bus.sample_valid = 1'b0;
    bus.load_ref     = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int waited;
    bus.sample_valid = 1'b0;
    bus.sample_chan  = '0;
    bus.sample_data  = '0;
    bus.load_ref     = 1'b0;
    bus.evt_ready    = 1'b1;
    do_reset();
    check("reset_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);

    // ON event, then reference has moved to 20
    threshold = 8'd10; refractory = '0; off_en = 1'b0;
    send(0, 20);
    check("on_count", 32'(fifo_count), 32'd1);
    check("on_chan", 32'(bus.evt_chan), 32'd0);
    check("on_pol", 32'(bus.evt_pol), 32'd1);
    send(0, 25);
    tick();
    check("ref_tracks_event", 32'(fifo_count), 32'd0);

    // OFF suppression still moves the reference
    send(1, 100, 1'b1);
    send(1, 50);
    send(1, 55);
    tick();
    check("off_suppressed", 32'(fifo_count), 32'd0);
    off_en = 1'b1;
    send(1, 100, 1'b1);
    send(1, 50);
    check("off_count", 32'(fifo_count), 32'd1);
    check("off_chan", 32'(bus.evt_chan), 32'd1);
    check("off_pol", 32'(bus.evt_pol), 32'd0);
    tick();

    // Refractory dead time of 3 cycles
    refractory = 4'd3;
    send(2, 200);
    check("refr_first", 32'(fifo_count), 32'd1);
    send(2, 0);
    send(2, 200);
    send(2, 0);
    check("refr_blocked", 32'(fifo_count), 32'd0);
    send(2, 0);
    check("refr_released", 32'(fifo_count), 32'd1);
    check("refr_released_pol", 32'(bus.evt_pol), 32'd0);
    tick();

    // Overflow: FIFO_DEPTH+2 events with the consumer stalled
    do_reset();
    refractory = '0; bus.evt_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) send(i % CHANNELS, 60 * (i / CHANNELS + 1));
    check("ovf_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    bus.evt_ready = 1'b1;
    repeat (FIFO_DEPTH + 2) tick();
    check("ovf_drained", 32'(fifo_count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous pop and push
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) send(i % CHANNELS, 60 * (i / CHANNELS + 1));
    bus.evt_ready = 1'b1;
    send(3, 250);
    bus.evt_ready = 1'b0;
    check("full_pushpop_count", 32'(fifo_count), 32'(FIFO_DEPTH));
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    bus.evt_ready = 1'b1;
    repeat (FIFO_DEPTH + 2) tick();
    check("full_pushpop_drained", 32'(fifo_count), 32'd0);

    // Reset flushes queued events
    do_reset();
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(i % CHANNELS, 60 * (i / CHANNELS + 1));
    check("queued5", 32'(fifo_count), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_valid", 32'(bus.evt_valid), 32'd0);
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);
    send(0, 5);
    check("post_reset_small", 32'(fifo_count), 32'd0);
    bus.evt_ready = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        threshold  = DATA_W'($urandom_range(0, 60));
        refractory = REF_W'($urandom_range(0, 5));
        off_en     = 1'($urandom_range(0, 1));
      end
      reset            = ($urandom_range(0, 599) == 0);
      bus.sample_valid = ($urandom_range(0, 3) != 0);
      bus.sample_chan  = CH_W'($urandom_range(0, CHANNELS - 1));
      bus.sample_data  = DATA_W'($urandom_range(0, 255));
      bus.load_ref     = ($urandom_range(0, 15) == 0);
      bus.evt_ready    = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                              : ($urandom_range(0, 3) == 0);
      tick();
    end

    // Drain, bounded
    reset = 1'b0;
    bus.sample_valid = 1'b0;
    bus.load_ref     = 1'b0;
    bus.evt_ready    = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * FIFO_DEPTH) begin
      tick();
      waited++;
    end
    tick();
    check("final_drain_model", 32'(exp_q.size()), 32'd0);
    check("final_drain_count", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_spike_encoder.md
# delta_spike_encoder

Parametrised, multi-channel delta-modulation spike encoder. It is the next-generation successor of the single-channel delta spike block. Each channel keeps its own reference level and refractory counter. When an incoming sample moves far enough from that channel's reference, the block emits an ON (rising) or OFF (falling) spike event. Events are queued in a FIFO and drained over a valid/ready interface toward the downstream spike router.

## Interface
Parameters:
- CHANNELS, 4: number of input channels (≥2); CH_W = clog2(CHANNELS)
- DATA_W, 8: sample, reference and threshold width
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2); CNT_W = clog2(FIFO_DEPTH)+1
- REF_W, 4: refractory counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- sample_valid  in  1  sample present this cycle
- sample_ready  out  1  always high except during reset
- sample_chan  in  CH_W  channel index of sample
- sample_data  in  DATA_W  unsigned sample
- threshold  in  DATA_W  unsigned spike threshold, shared by all channels
- refractory  in  REF_W  dead-time cycles reloaded after each event
- off_en  in  1  1 = emit OFF events; 0 = suppress them
- load_ref  in  1  with an accepted sample: force ref[chan] <= sample_data, no event
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pops head when evt_valid & evt_ready
- evt_chan  out  CH_W  head event channel
- evt_pol  out  1  head event polarity: 1 = ON, 0 = OFF
- fifo_count  out  CNT_W  occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Accept: sample_valid & sample_ready. Out-of-range sample_chan (≥CHANNELS) is ignored: no state change.
- Difference: diff = sample_data − ref[chan], signed, DATA_W+1 bits, no saturation.
- Priority on an accepted sample for channel c:
  1. load_ref=1: ref[c] <= sample_data; no event; rc[c] unchanged.
  2. rc[c]≠0: no event; ref[c] unchanged.
  3. diff > threshold (strict): ON event; ref[c] <= sample_data; rc[c] <= refractory.
  4. −diff > threshold: ref[c] <= sample_data; rc[c] <= refractory; an OFF event is generated only if off_en=1.
  5. Otherwise: nothing changes. The reference does not track sub-threshold drift, so slow drift accumulates.
- Refractory: every cycle, each nonzero rc[x] decrements by 1. A reload to the same channel in the same cycle wins over the decrement. refractory=0 disables dead time.
- FIFO: a generated event is pushed as {chan, pol}.
  - Full with no pop in the same cycle: the event is dropped and overflow <= 1. The rest of the update (ref, rc) still happens.
  - Full with a pop in the same cycle: the push is accepted; count stays FIFO_DEPTH.
  - Empty with a push in the same cycle: count goes to 1; there is no bypass in that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on reset.
- Reset values: all ref and rc = 0; FIFO flushed; evt_valid=0; fifo_count=0; overflow=0; sample_ready=0 while reset=1. Asserting reset mid-stream discards all queued events.

## Timing
- Sample accepted at edge k: the ref/rc update and the FIFO push take effect at edge k.
- Event latency is 1 cycle: evt_valid and head fields are valid in the cycle after acceptance when the FIFO was empty.
- Back-to-back samples on the same channel compare against the reference updated at the previous edge. There is no hazard stall, and the block sustains one sample per cycle.
- evt_chan and evt_pol are stable while evt_valid=1 and evt_ready=0. The head advances one cycle after a pop.
- fifo_count reflects pushes and pops registered at each edge.

## Test plan
- Reset, then ch0 data 20 with thr 10 (ref 0) → ON event ch0. ref0=20 checked by following with ch0 data 25: no event.
- off_en=0: ch1 ref 100 (via load_ref), then data 50, thr 10 → no event. Then data 55 → no event, since ref1 is now 50. Repeat with off_en=1 → OFF event ch1.
- refractory=3: ch2 alternates 0/200/0/200 every cycle, thr 10 → only the first event appears. An event is emitted again on the 4th cycle after the first.
- evt_ready=0, FIFO_DEPTH+2 ON events → fifo_count=FIFO_DEPTH, overflow=1. Drain order matches the first FIFO_DEPTH events.
- Full FIFO with simultaneous pop and push → count stays FIFO_DEPTH, overflow stays 0, and the new event is at the tail.
- Reset asserted with 5 queued events → the next cycle shows evt_valid=0, fifo_count=0, overflow=0. ch0 data 5 with thr 10 → no event.
